mult_sequencer: RTL and testbench

//  Iterative shift-add multiplier sequencer for MULT/MULTU in the execute stage.

---
 rtl/mult_sequencer.sv | 159 +++++++++++++++
 tb/tb_mult_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mult_sequencer.sv
// ---------------------------------------------------------------------------
// mult_sequencer
//   Iterative shift-add multiplier for MULT/MULTU in the execute stage.
//   The operands are captured on start. The unit runs one partial-product
//   step per cycle for WIDTH cycles. A final fix-up cycle applies the sign,
//   and the 2*WIDTH-bit product is written into the architectural HI/LO
//   registers.
//
// Ports
//   clk_i         clock, all state updates on the rising edge
//   reset_i       synchronous active-high reset
//   start_i       start request from decode, sampled only in IDLE
//   is_signed_i   1 = MULT (two's complement), 0 = MULTU
//   srca_i        multiplicand (rs after forwarding)
//   srcb_i        multiplier (rt after forwarding)
//   mfhid_i       MFHI in decode stage
//   mflod_i       MFLO in decode stage
//   hi_o, lo_o    architectural HI / LO registers
//   busy_o        operation in flight (state != IDLE)
//   hilo_stall_o  busy & (mfhid | mflod), combinational into hazard unit
//   done_o        one-cycle pulse, HI/LO hold the new product this cycle
// ---------------------------------------------------------------------------
module mult_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic             is_signed_i,
  input  logic [WIDTH-1:0] srca_i,
  input  logic [WIDTH-1:0] srcb_i,
  input  logic             mfhid_i,
  input  logic             mflod_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             busy_o,
  output logic             hilo_stall_o,
  output logic             done_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        count_q, count_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic                 neg_q, neg_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 done_q, done_d;

  logic [WIDTH:0]       sum_s;
  logic [WIDTH-1:0]     addend_s;
  logic [2*WIDTH-1:0]   product_s;
  logic [WIDTH-1:0]     abs_a_s, abs_b_s;

  // Two's-complement magnitude. The most negative value maps onto itself,
  // and that result is correct when it is read as unsigned 2^(WIDTH-1).
  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    if (v[WIDTH-1]) begin
      r = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      r = v;
    end
    return r;
  endfunction

  // Next-state, datapath and output-enable logic
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    neg_d     = neg_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    abs_a_s   = abs_val(srca_i);
    abs_b_s   = abs_val(srcb_i);
    addend_s  = acc_q[0] ? mcand_q : {WIDTH{1'b0}};
    // The sum is one bit wider than an operand so that the carry shifts
    // into the accumulator instead of being lost.
    sum_s     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend_s};
    product_s = neg_q ? (~acc_q + {{(2*WIDTH-1){1'b0}}, 1'b1}) : acc_q;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          if (is_signed_i) begin
            mcand_d = abs_a_s;
            acc_d   = {{WIDTH{1'b0}}, abs_b_s};
          end else begin
            mcand_d = srca_i;
            acc_d   = {{WIDTH{1'b0}}, srcb_i};
          end
          neg_d   = is_signed_i & (srca_i[WIDTH-1] ^ srcb_i[WIDTH-1]);
          count_d = CW'(WIDTH - 1);
          state_d = ST_CALC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CALC: begin
        acc_d = {sum_s, acc_q[WIDTH-1:1]};
        if (count_q == {CW{1'b0}}) begin
          state_d = ST_FIX;
        end else begin
          count_d = count_q - {{(CW-1){1'b0}}, 1'b1};
        end
      end
      ST_FIX: begin
        hi_d    = product_s[2*WIDTH-1:WIDTH];
        lo_d    = product_s[WIDTH-1:0];
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      count_q <= {CW{1'b0}};
      acc_q   <= {(2*WIDTH){1'b0}};
      mcand_q <= {WIDTH{1'b0}};
      neg_q   <= 1'b0;
      hi_q    <= {WIDTH{1'b0}};
      lo_q    <= {WIDTH{1'b0}};
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      neg_q   <= neg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign hi_o         = hi_q;
  assign lo_o         = lo_q;
  assign done_o       = done_q;
  assign busy_o       = (state_q != ST_IDLE);
  assign hilo_stall_o = busy_o & (mfhid_i | mflod_i);

endmodule

// File: tb/tb_mult_sequencer.sv
module tb_mult_sequencer;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         is_signed;
  logic [W-1:0] srca;
  logic [W-1:0] srcb;
  logic         mfhid;
  logic         mflod;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         busy;
  logic         hilo_stall;
  logic         done;

  int n_checks = 0;
  int n_fail   = 0;

  // HI/LO values the bench expects to be held until the next FIX edge
  logic [W-1:0] prev_hi = 32'h0;
  logic [W-1:0] prev_lo = 32'h0;

  mult_sequencer #(.WIDTH(W)) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .start_i      (start),
    .is_signed_i  (is_signed),
    .srca_i       (srca),
    .srcb_i       (srcb),
    .mfhid_i      (mfhid),
    .mflod_i      (mflod),
    .hi_o         (hi),
    .lo_o         (lo),
    .busy_o       (busy),
    .hilo_stall_o (hilo_stall),
    .done_o       (done)
  );

  always #5 clk = ~clk;

  // Called at a negedge. It drives start now and runs the operation until
  // the done cycle, then returns at the negedge of that done cycle.
  // mid_start raises a second start pulse partway through the operation.
  task automatic run_mult(input string name, input logic sgn,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo,
                          input logic stall_chk, input logic mid_start);
    int cyc;
    start     = 1'b1;
    is_signed = sgn;
    srca      = a;
    srcb      = b;
    @(negedge clk);
    start     = 1'b0;
    // Changing the operands after the start cycle must have no effect
    srca      = ~a;
    srcb      = b ^ 32'h5A5A_5A5A;
    is_signed = ~sgn;
    cyc = 0;
    while (busy && cyc < 100) begin
      cyc++;
      n_checks++;
      if (done !== 1'b0) begin
        n_fail++;
        $display("FAIL %s done_while_busy cyc=%0d got=%b exp=0", name, cyc, done);
      end
      n_checks++;
      if (hi !== prev_hi || lo !== prev_lo) begin
        n_fail++;
        $display("FAIL %s hilo_hold cyc=%0d got=%h_%h exp=%h_%h", name, cyc, hi, lo, prev_hi, prev_lo);
      end
      if (stall_chk) begin
        n_checks++;
        if (hilo_stall !== 1'b1) begin
          n_fail++;
          $display("FAIL %s hilo_stall_busy cyc=%0d got=%b exp=1", name, cyc, hilo_stall);
        end
      end
      start = (mid_start && cyc == 5) ? 1'b1 : 1'b0;
      if (mid_start && cyc == 5) begin
        srca = 32'd100;
        srcb = 32'd100;
      end
      @(negedge clk);
    end
    start = 1'b0;
    n_checks++;
    if (cyc !== W + 1) begin
      n_fail++;
      $display("FAIL %s busy_cycles got=%0d exp=%0d", name, cyc, W + 1);
    end
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL %s done_pulse got=%b exp=1", name, done);
    end
    n_checks++;
    if (hi !== exp_hi || lo !== exp_lo) begin
      n_fail++;
      $display("FAIL %s product got=%h_%h exp=%h_%h", name, hi, lo, exp_hi, exp_lo);
    end
    if (stall_chk) begin
      n_checks++;
      if (hilo_stall !== 1'b0) begin
        n_fail++;
        $display("FAIL %s hilo_stall_done got=%b exp=0", name, hilo_stall);
      end
    end
    prev_hi = exp_hi;
    prev_lo = exp_lo;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    is_signed = 1'b0;
    srca = 32'h0;
    srcb = 32'h0;
    mfhid = 1'b1;
    mflod = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hilo_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl got busy=%b done=%b stall=%b exp=0/0/0", busy, done, hilo_stall);
    end
    n_checks++;
    if (hi !== 32'h0 || lo !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_hilo got=%h_%h exp=0_0", hi, lo);
    end
    mfhid = 1'b0;
  endtask

  task automatic test_multu();
    run_mult("multu_7x6", 1'b0, 32'd7, 32'd6, 32'h0000_0000, 32'h0000_002A, 1'b0, 1'b0);
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL multu_7x6 done_one_cycle got=%b exp=0", done);
    end
    run_mult("multu_max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b0);
    @(negedge clk);
  endtask

  task automatic test_mult_signed();
    run_mult("mult_m3x5", 1'b1, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 1'b0);
    @(negedge clk);
    run_mult("mult_m4xm4", 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0010, 1'b0, 1'b0);
    @(negedge clk);
    run_mult("mult_min_sq", 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 1'b0);
    @(negedge clk);
    run_mult("mult_min_x1", 1'b1, 32'h8000_0000, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b0);
    @(negedge clk);
  endtask

  task automatic test_stall_and_restart();
    mfhid = 1'b1;
    run_mult("stall_mid_start", 1'b0, 32'd1000, 32'd3000, 32'h0000_0000, 32'h002D_C6C0, 1'b1, 1'b1);
    mfhid = 1'b0;
    @(negedge clk);
    mflod = 1'b1;
    run_mult("stall_mflo", 1'b1, 32'd12345, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_9F8E, 1'b1, 1'b0);
    mflod = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    run_mult("b2b_first", 1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0);
    // A start issued in the done cycle is accepted immediately
    run_mult("b2b_second", 1'b0, 32'd9, 32'd9, 32'h0000_0000, 32'h0000_0051, 1'b0, 1'b0);
    @(negedge clk);
  endtask

  task automatic test_mid_reset();
    start = 1'b1;
    is_signed = 1'b0;
    srca = 32'd7;
    srcb = 32'd6;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset busy_before got=%b exp=1", busy);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset ctrl got busy=%b done=%b exp=0/0", busy, done);
    end
    n_checks++;
    if (hi !== 32'h0 || lo !== 32'h0) begin
      n_fail++;
      $display("FAIL mid_reset hilo got=%h_%h exp=0_0", hi, lo);
    end
    prev_hi = 32'h0;
    prev_lo = 32'h0;
    // The aborted operation must never write HI/LO later
    repeat (30) @(negedge clk);
    n_checks++;
    if (hi !== 32'h0 || lo !== 32'h0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset no_late_write got=%h_%h done=%b exp=0_0 0", hi, lo, done);
    end
    run_mult("after_reset_2x3", 1'b0, 32'd2, 32'd3, 32'h0000_0000, 32'h0000_0006, 1'b0, 1'b0);
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_multu();
    test_mult_signed();
    test_stall_and_restart();
    test_back_to_back();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
